// File: rtl/input_setup.sv
// Skews 2x2 tiles from the unified buffer onto two staggered systolic-array row operands.
// Define INPUT_SETUP_PINGPONG_EN to add a pending tile register for gap-free back-to-back tiles.
module input_setup (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] ub_00,
    input  logic [31:0] ub_01,
    input  logic [31:0] ub_10,
    input  logic [31:0] ub_11,
    output logic [31:0] a_in1,
    output logic [31:0] a_in2,
    output logic        valid1,
    output logic        valid2,
    output logic        tile_done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, PH0, PH1, PH2} state_e;

    typedef struct packed {
        logic [31:0] w00;
        logic [31:0] w01;
        logic [31:0] w10;
        logic [31:0] w11;
    } tile_t;

    state_e      state_q, state_d;
    tile_t       act_q, act_d;
    tile_t       in_tile;
    logic        accept;

    logic [31:0] a1_q, a1_d;
    logic [31:0] a2_q, a2_d;
    logic        v1_q, v1_d;
    logic        v2_q, v2_d;
    logic        done_q, done_d;

    assign in_tile = '{w00: ub_00, w01: ub_01, w10: ub_10, w11: ub_11};
    assign accept  = load_valid && load_ready;
    assign busy    = (state_q != IDLE);

`ifdef INPUT_SETUP_PINGPONG_EN
    tile_t pend_q, pend_d;
    logic  pend_valid_q, pend_valid_d;

    assign load_ready = !reset && !pend_valid_q;
`else
    assign load_ready = !reset && (state_q == IDLE);
`endif

    // Next-state and tile-register steering.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d = state_q;
        act_d   = act_q;
`ifdef INPUT_SETUP_PINGPONG_EN
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PH0;
                    act_d   = in_tile;
                end
            end
            PH0, PH1: begin
                state_d = (state_q == PH0) ? PH1 : PH2;
`ifdef INPUT_SETUP_PINGPONG_EN
                if (accept) begin
                    pend_d       = in_tile;
                    pend_valid_d = 1'b1;
                end
`endif
            end
            PH2: begin
                state_d = IDLE;
`ifdef INPUT_SETUP_PINGPONG_EN
                // The active register is free here: its last word is being registered this edge.
                if (pend_valid_q) begin
                    state_d      = PH0;
                    act_d        = pend_q;
                    pend_valid_d = 1'b0;
                end else if (accept) begin
                    state_d = PH0;
                    act_d   = in_tile;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; registered, so each phase shows up the cycle after it is entered.
    always_comb begin
        a1_d   = '0;
        a2_d   = '0;
        v1_d   = 1'b0;
        v2_d   = 1'b0;
        done_d = 1'b0;
        unique case (state_q)
            PH0: begin
                a1_d = act_q.w00;
                v1_d = 1'b1;
            end
            PH1: begin
                a1_d = act_q.w01;
                v1_d = 1'b1;
                a2_d = act_q.w10;
                v2_d = 1'b1;
            end
            PH2: begin
                a2_d   = act_q.w11;
                v2_d   = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            a1_q    <= '0;
            a2_q    <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            done_q  <= done_d;
        end
    end

    // NOTE: tile data registers are not reset; the control state decides whether they are ever read.
    always_ff @(posedge clk) begin
        act_q <= act_d;
    end

`ifdef INPUT_SETUP_PINGPONG_EN
    always_ff @(posedge clk) begin
        pend_q <= pend_d;
        if (reset) pend_valid_q <= 1'b0;
        else       pend_valid_q <= pend_valid_d;
    end
`endif

    assign a_in1     = a1_q;
    assign a_in2     = a2_q;
    assign valid1    = v1_q;
    assign valid2    = v2_q;
    assign tile_done = done_q;

endmodule

// File: tb/tb_input_setup.sv
// Scoreboard bench for input_setup: expected skewed words are queued at accept time and
// popped on the edge they are due. Works with or without INPUT_SETUP_PINGPONG_EN.
module tb_input_setup;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] ub_00, ub_01, ub_10, ub_11;
    logic [31:0] a_in1, a_in2;
    logic        valid1, valid2, tile_done, busy;

    input_setup dut (
        .clk       (clk),
        .reset     (reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .ub_00     (ub_00),
        .ub_01     (ub_01),
        .ub_10     (ub_10),
        .ub_11     (ub_11),
        .a_in1     (a_in1),
        .a_in2     (a_in2),
        .valid1    (valid1),
        .valid2    (valid2),
        .tile_done (tile_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

`ifdef INPUT_SETUP_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    // word = {a_in1, a_in2, valid1, valid2, tile_done}
    typedef struct {
        int          edge_n;
        logic [66:0] word;
    } exp_t;

    exp_t sb[$];
    int   passes     = 0;
    int   fails      = 0;
    int   total      = 0;
    int   e_last     = 0;
    int   last_start = -100;

    task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s @edge %0d: observed %h expected %h", tag, e_last, obs, exp);
        end
    endtask

    // State after edge e_last is busy iff a tile word is due after the following edge.
    function automatic bit busy_exp();
        foreach (sb[i]) if (sb[i].edge_n == e_last + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ready_exp();
        if (PP) return !(last_start > e_last);
        return !busy_exp();
    endfunction

    task automatic step(input bit rst, input bit lv,
                        input logic [31:0] w00, input logic [31:0] w01,
                        input logic [31:0] w10, input logic [31:0] w11,
                        output bit acc);
        int   start;
        exp_t e;
        logic [66:0] exp_word;
        reset      = rst;
        load_valid = lv;
        ub_00 = w00; ub_01 = w01; ub_10 = w10; ub_11 = w11;
        #1;
        check("load_ready", {66'd0, load_ready}, {66'd0, (!rst && ready_exp())});
        acc = !rst && lv && ready_exp();
        if (acc) begin
            start = (PP && busy_exp()) ? last_start + 3 : e_last + 1;
            e.edge_n = start + 1; e.word = {w00, 32'd0, 1'b1, 1'b0, 1'b0}; sb.push_back(e);
            e.edge_n = start + 2; e.word = {w01, w10,   1'b1, 1'b1, 1'b0}; sb.push_back(e);
            e.edge_n = start + 3; e.word = {32'd0, w11, 1'b0, 1'b1, 1'b1}; sb.push_back(e);
            last_start = start;
        end
        @(posedge clk);
        #1;
        e_last++;
        if (rst) begin
            sb.delete();
            last_start = -100;
        end
        exp_word = '0;
        if (sb.size() > 0 && sb[0].edge_n == e_last) exp_word = sb.pop_front().word;
        check("outputs", {a_in1, a_in2, valid1, valid2, tile_done}, exp_word);
        check("busy", {66'd0, busy}, {66'd0, busy_exp()});
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom, acc);
    endtask

    initial begin
        bit          acc;
        int          idx;
        logic [31:0] t[3][4];

        reset = 1'b1; load_valid = 1'b0;
        ub_00 = '0; ub_01 = '0; ub_10 = '0; ub_11 = '0;

        step(1'b1, 1'b0, 0, 0, 0, 0, acc);
        step(1'b1, 1'b1, 1, 2, 3, 4, acc);

        // Single tile, then drain.
        step(1'b0, 1'b1, 32'd11, 32'd12, 32'd21, 32'd22, acc);
        idle(5);

        // Idle hygiene with random bus contents.
        idle(10);

        // Full-width words and abort on reset at the PH1 edge.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'hDEAD_BEEF, 32'h0123_4567, acc);
        idle(1);
        step(1'b1, 1'b0, 0, 0, 0, 0, acc);
        idle(4);

        // Continuous offer of three tiles; ready gating decides when each is taken.
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 4; j++) t[k][j] = {8'hA0 + 8'(k), 8'(j), 16'($urandom)};
        idx = 0;
        for (int k = 0; k < 20 && idx < 3; k++) begin
            step(1'b0, 1'b1, t[idx][0], t[idx][1], t[idx][2], t[idx][3], acc);
            if (acc) idx++;
        end
        check("b2b_accepted", 67'(idx), 67'd3);
        idle(6);

        // Random single tiles with gaps, to exercise accept at the PH2 boundary in ping-pong mode.
        idx = 0;
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom, acc);
        end
        idle(6);
        check("scoreboard_empty", 67'(sb.size()), 67'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
